// File: rtl/cam_table_engine_if.sv
// Request/result bundle between the CAM port arbiter (master) and the
// table engine (slave).
//
// Handshake: every stream is valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both high. Once valid is raised, the
// source keeps valid and its payload stable until that transfer. Ready may
// be driven combinationally and may change while valid is low.
`timescale 1ns/1ps
interface cam_table_engine_if #(
  parameter int KEY_SIZE          = 8,
  parameter int VALUE_SIZE        = 32,
  parameter int UPDATE_USER_WIDTH = 4,
  parameter int LOOKUP_USER_WIDTH = 4
);
  logic [KEY_SIZE-1:0]          update_req_index;
  logic [VALUE_SIZE-1:0]        update_req_data;
  logic [UPDATE_USER_WIDTH-1:0] update_req_user;
  logic                         update_req_valid;
  logic                         update_req_ready;

  logic [KEY_SIZE-1:0]          lookup_req_index;
  logic [LOOKUP_USER_WIDTH-1:0] lookup_req_user;
  logic                         lookup_req_valid;
  logic                         lookup_req_ready;

  logic [VALUE_SIZE-1:0]        lookup_value_data;
  logic                         lookup_value_hit;
  logic [LOOKUP_USER_WIDTH-1:0] lookup_value_user;
  logic                         lookup_value_valid;
  logic                         lookup_value_ready;

  modport master (
    output update_req_index, update_req_data, update_req_user, update_req_valid,
    input  update_req_ready,
    output lookup_req_index, lookup_req_user, lookup_req_valid,
    input  lookup_req_ready,
    input  lookup_value_data, lookup_value_hit, lookup_value_user, lookup_value_valid,
    output lookup_value_ready
  );

  modport slave (
    input  update_req_index, update_req_data, update_req_user, update_req_valid,
    output update_req_ready,
    input  lookup_req_index, lookup_req_user, lookup_req_valid,
    output lookup_req_ready,
    output lookup_value_data, lookup_value_hit, lookup_value_user, lookup_value_valid,
    input  lookup_value_ready
  );
endinterface

// File: rtl/cam_table_engine.sv
// Associative key/value table. Updates insert or overwrite an entry in the
// same cycle they are accepted. Lookups run through a two-register pipeline
// (S1 request, S2 result) and return value, hit flag and echoed tag.
`timescale 1ns/1ps
module cam_table_engine #(
  parameter int                          TABLE_SIZE        = 16,
  parameter int                          KEY_SIZE          = 8,
  parameter int                          VALUE_SIZE        = 32,
  parameter int                          UPDATE_USER_WIDTH = 4,
  parameter int                          LOOKUP_USER_WIDTH = 4,
  parameter logic [VALUE_SIZE-1:0]       MISS_VALUE        = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              table_clear,
  cam_table_engine_if.slave                 bus,
  output logic [$clog2(TABLE_SIZE+1)-1:0]   entry_count
);

  localparam int IW = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;
  localparam int CW = $clog2(TABLE_SIZE+1);

  logic [TABLE_SIZE-1:0] entry_valid;
  logic [KEY_SIZE-1:0]   entry_key   [TABLE_SIZE];
  logic [VALUE_SIZE-1:0] entry_value [TABLE_SIZE];
  logic [IW-1:0]         victim;

  logic          upd_fire;
  logic          upd_match;
  logic          upd_free;
  logic [IW-1:0] match_idx;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] wr_idx;

  logic                         s1_valid;
  logic [KEY_SIZE-1:0]          s1_key;
  logic [LOOKUP_USER_WIDTH-1:0] s1_user;
  logic                         s2_adv;
  logic                         lk_hit;
  logic [VALUE_SIZE-1:0]        lk_data;

  // The update tag only travels with the request; it has no effect here.
  logic unused_update_user;
  assign unused_update_user = ^bus.update_req_user;

  // A clear pulse blocks updates so none is silently wiped in the same edge.
  assign bus.update_req_ready = rst && !table_clear;
  assign upd_fire             = bus.update_req_valid && bus.update_req_ready;

  assign s2_adv               = !bus.lookup_value_valid || bus.lookup_value_ready;
  assign bus.lookup_req_ready = rst && (!s1_valid || s2_adv);

  // Find an existing entry with the update key and the lowest free slot
  // (descending scan so the lowest index wins).
  always_comb begin
    upd_match = 1'b0;
    match_idx = '0;
    upd_free  = 1'b0;
    free_idx  = '0;
    for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
      if (entry_valid[i] && (entry_key[i] == bus.update_req_index)) begin
        upd_match = 1'b1;
        match_idx = IW'(i);
      end
      if (!entry_valid[i]) begin
        upd_free = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign wr_idx = upd_match ? match_idx : (upd_free ? free_idx : victim);

  // Compare the S1 key against the table as it stands before this edge.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = MISS_VALUE;
    for (int i = 0; i < TABLE_SIZE; i++) begin
      if (entry_valid[i] && (entry_key[i] == s1_key)) begin
        lk_hit  = 1'b1;
        lk_data = entry_value[i];
      end
    end
  end

  // Entry valid bits: cleared wholesale, set on the written slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_valid <= '0;
    end else if (table_clear) begin
      entry_valid <= '0;
    end else if (upd_fire) begin
      entry_valid[wr_idx] <= 1'b1;
    end
  end

  // Key/value storage carries no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (upd_fire) begin
      entry_key[wr_idx]   <= bus.update_req_index;
      entry_value[wr_idx] <= bus.update_req_data;
    end
  end

  // Occupancy count and round-robin victim for full-table replacement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_count <= '0;
      victim      <= '0;
    end else if (table_clear) begin
      entry_count <= '0;
      victim      <= '0;
    end else if (upd_fire && !upd_match) begin
      if (upd_free) begin
        entry_count <= entry_count + CW'(1);
      end else if (victim == IW'(TABLE_SIZE - 1)) begin
        victim <= '0;
      end else begin
        victim <= victim + 1'b1;
      end
    end
  end

  // S1: capture a request whenever the slot is free or draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_key   <= '0;
      s1_user  <= '0;
    end else if (bus.lookup_req_ready) begin
      s1_valid <= bus.lookup_req_valid;
      s1_key   <= bus.lookup_req_index;
      s1_user  <= bus.lookup_req_user;
    end
  end

  // S2: result register, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.lookup_value_valid <= 1'b0;
      bus.lookup_value_hit   <= 1'b0;
      bus.lookup_value_data  <= '0;
      bus.lookup_value_user  <= '0;
    end else if (s2_adv) begin
      bus.lookup_value_valid <= s1_valid;
      if (s1_valid) begin
        bus.lookup_value_hit  <= lk_hit;
        bus.lookup_value_data <= lk_data;
        bus.lookup_value_user <= s1_user;
      end
    end
  end

endmodule

// File: tb/tb_cam_table_engine.sv
// Bench for cam_table_engine: directed sequences, a slot-level table model
// with an expected-result queue checked every cycle, and literal spot checks.
`timescale 1ns/1ps
module tb_cam_table_engine;

  localparam int TS = 16;
  localparam int KS = 8;
  localparam int VS = 32;
  localparam int UU = 4;
  localparam int LU = 4;
  localparam int CW = $clog2(TS + 1);
  localparam logic [VS-1:0] MISS = '0;
  localparam int EW = 1 + VS + LU;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          table_clear = 1'b0;
  logic [CW-1:0] entry_count;

  always #5 clk = ~clk;

  cam_table_engine_if #(
    .KEY_SIZE(KS), .VALUE_SIZE(VS),
    .UPDATE_USER_WIDTH(UU), .LOOKUP_USER_WIDTH(LU)
  ) bus ();

  cam_table_engine #(
    .TABLE_SIZE(TS), .KEY_SIZE(KS), .VALUE_SIZE(VS),
    .UPDATE_USER_WIDTH(UU), .LOOKUP_USER_WIDTH(LU), .MISS_VALUE(MISS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .table_clear(table_clear),
    .bus(bus),
    .entry_count(entry_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_valid [TS];
  logic [KS-1:0] m_key   [TS];
  logic [VS-1:0] m_val   [TS];
  int            m_victim;

  function automatic void model_clear();
    for (int i = 0; i < TS; i++) m_valid[i] = 1'b0;
    m_victim = 0;
  endfunction

  function automatic void model_update(input logic [KS-1:0] k, input logic [VS-1:0] v);
    for (int i = 0; i < TS; i++)
      if (m_valid[i] && m_key[i] == k) begin
        m_val[i] = v;
        return;
      end
    for (int i = 0; i < TS; i++)
      if (!m_valid[i]) begin
        m_valid[i] = 1'b1; m_key[i] = k; m_val[i] = v;
        return;
      end
    m_key[m_victim] = k;
    m_val[m_victim] = v;
    m_victim = (m_victim + 1) % TS;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < TS; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  function automatic logic [EW-1:0] model_lookup(input logic [KS-1:0] k, input logic [LU-1:0] u);
    for (int i = 0; i < TS; i++)
      if (m_valid[i] && m_key[i] == k) return {1'b1, m_val[i], u};
    return {1'b0, MISS, u};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q [$];
  bit            pend_v = 1'b0;
  logic [KS-1:0] pend_key;
  logic [LU-1:0] pend_user;
  int            lk_acc_cnt = 0;
  bit            rec_on = 1'b0;
  int            rec_user [$];
  int            rec_cyc  [$];

  // Sampled mid-cycle: check outputs, then fold in the handshakes that the
  // coming edge will perform. A request accepted at one edge is compared
  // against the table as it stands just before the following edge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      pend_v = 1'b0;
      model_clear();
    end else begin
      if (bus.lookup_value_valid) begin
        if (exp_q.size() == 0) begin
          chk("stale_result", 1, 0);
        end else begin
          chk("result", {bus.lookup_value_hit, bus.lookup_value_data, bus.lookup_value_user},
              exp_q[0]);
          if (bus.lookup_value_ready) begin
            void'(exp_q.pop_front());
            if (rec_on) begin
              rec_user.push_back(int'(bus.lookup_value_user));
              rec_cyc.push_back(cyc);
            end
          end
        end
      end else if (exp_q.size() != 0) begin
        chk("result_missing", 0, 1);
      end
      chk("entry_count", entry_count, model_count());
      chk("update_ready", bus.update_req_ready, !table_clear);
      if (pend_v) exp_q.push_back(model_lookup(pend_key, pend_user));
      pend_v    = bus.lookup_req_valid && bus.lookup_req_ready;
      pend_key  = bus.lookup_req_index;
      pend_user = bus.lookup_req_user;
      if (pend_v) lk_acc_cnt++;
      if (table_clear) model_clear();
      else if (bus.update_req_valid && bus.update_req_ready)
        model_update(bus.update_req_index, bus.update_req_data);
    end
  end

  // ---------------- drivers (called 1ns after a rising edge) ----------------
  task automatic do_update(input logic [KS-1:0] k, input logic [VS-1:0] v);
    bus.update_req_index = k;
    bus.update_req_data  = v;
    bus.update_req_user  = UU'($urandom_range(0, 15));
    bus.update_req_valid = 1'b1;
    @(posedge clk); #1;
    bus.update_req_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [KS-1:0] k, input logic [LU-1:0] u);
    logic r;
    bus.lookup_req_index = k;
    bus.lookup_req_user  = u;
    bus.lookup_req_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk); r = bus.lookup_req_ready;
      @(posedge clk); #1;
      if (r) break;
      if (n == 39) chk("lookup_accept_timeout", 0, 1);
    end
    bus.lookup_req_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [VS-1:0] d, output logic h, output logic [LU-1:0] u);
    bit got = 1'b0;
    d = '0; h = 1'b0; u = '0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (bus.lookup_value_valid && bus.lookup_value_ready) begin
        d = bus.lookup_value_data; h = bus.lookup_value_hit; u = bus.lookup_value_user;
        got = 1'b1;
      end
    end
    if (!got) chk("result_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic lookup_check(input string name, input logic [KS-1:0] k, input logic [LU-1:0] u,
                              input logic eh, input logic [VS-1:0] ed);
    logic [VS-1:0] d; logic h; logic [LU-1:0] uo;
    do_lookup(k, u);
    wait_result(d, h, uo);
    chk({name, "_hit"}, h, eh);
    chk({name, "_data"}, d, ed);
    chk({name, "_user"}, uo, u);
  endtask

  task automatic pulse_clear();
    table_clear = 1'b1;
    @(posedge clk); #1;
    table_clear = 1'b0;
  endtask

  function automatic logic [VS-1:0] fill_val(input logic [KS-1:0] k);
    return 32'hA5A5_A500 | {24'h0, k};
  endfunction

  // ---------------- directed sequence ----------------
  logic [KS-1:0] keys4 [6] = '{8'h20, 8'h99, 8'h4F, 8'h21, 8'h50, 8'h41};

  initial begin
    bus.update_req_index = '0; bus.update_req_data = '0; bus.update_req_user = '0;
    bus.update_req_valid = 1'b0;
    bus.lookup_req_index = '0; bus.lookup_req_user = '0; bus.lookup_req_valid = 1'b0;
    bus.lookup_value_ready = 1'b1;

    // Reset values
    #2 rst = 1'b0;
    #1;
    chk("rst_value_valid", bus.lookup_value_valid, 0);
    chk("rst_value_data", bus.lookup_value_data, 0);
    chk("rst_upd_ready", bus.update_req_ready, 0);
    chk("rst_lk_ready", bus.lookup_req_ready, 0);
    chk("rst_count", entry_count, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Miss on an empty table, then insert and hit
    lookup_check("empty_miss", 8'h55, 4'd9, 1'b0, MISS);
    do_update(8'h10, 32'hDEAD_BEEF);
    lookup_check("t1", 8'h10, 4'd3, 1'b1, 32'hDEAD_BEEF);
    chk("t1_count", entry_count, 1);

    // Overwrite keeps count
    do_update(8'h10, 32'h1);
    chk("t2_count", entry_count, 1);
    lookup_check("t2", 8'h10, 4'd4, 1'b1, 32'h1);

    // Fill, then replace via victim pointer
    pulse_clear();
    for (int k = 0; k < 16; k++) do_update(KS'(k), fill_val(KS'(k)));
    chk("t3_fill_count", entry_count, 16);
    do_update(8'h20, fill_val(8'h20));
    do_update(8'h21, fill_val(8'h21));
    lookup_check("t3_k00", 8'h00, 4'd1, 1'b0, MISS);
    lookup_check("t3_k01", 8'h01, 4'd2, 1'b0, MISS);
    lookup_check("t3_k20", 8'h20, 4'd5, 1'b1, fill_val(8'h20));
    lookup_check("t3_k02", 8'h02, 4'd6, 1'b1, fill_val(8'h02));
    chk("t3_count", entry_count, 16);
    for (int k = 8'h40; k < 8'h50; k++) do_update(KS'(k), fill_val(KS'(k)));
    do_update(8'h50, fill_val(8'h50));
    lookup_check("t3_k40", 8'h40, 4'd7, 1'b0, MISS);
    lookup_check("t3_k4f", 8'h4F, 4'd8, 1'b1, fill_val(8'h4F));
    lookup_check("t3_k50", 8'h50, 4'd9, 1'b1, fill_val(8'h50));
    chk("t3_count2", entry_count, 16);

    // Backpressure: six requests against a stalled consumer
    begin
      int acc_base;
      acc_base = lk_acc_cnt;
      bus.lookup_value_ready = 1'b0;
      fork
        begin
          for (int i = 0; i < 6; i++) do_lookup(keys4[i], LU'(i));
        end
        begin
          repeat (8) @(posedge clk);
          #2;
          chk("bp_accepted", lk_acc_cnt - acc_base, 2);
          chk("bp_req_ready", bus.lookup_req_ready, 0);
          chk("bp_out_valid", bus.lookup_value_valid, 1);
          chk("bp_front_user", bus.lookup_value_user, 0);
          rec_on = 1'b1;
          bus.lookup_value_ready = 1'b1;
        end
      join
      for (int n = 0; n < 30 && rec_user.size() < 6; n++) @(posedge clk);
      #1;
      rec_on = 1'b0;
      chk("bp_result_count", rec_user.size(), 6);
      for (int i = 0; i < rec_user.size(); i++) begin
        chk("bp_order", rec_user[i], i);
        if (i > 0) chk("bp_rate", rec_cyc[i] - rec_cyc[i-1], 1);
      end
    end

    // Same-edge update/compare hazard, then clear blocking an update
    do_lookup(8'h30, 4'd10);
    do_update(8'h30, 32'h7);
    begin
      logic [VS-1:0] d; logic h; logic [LU-1:0] uo;
      wait_result(d, h, uo);
      chk("t5_hazard_hit", h, 0);
      chk("t5_hazard_data", d, MISS);
      chk("t5_hazard_user", uo, 10);
    end
    lookup_check("t5_k30", 8'h30, 4'd11, 1'b1, 32'h7);
    table_clear = 1'b1;
    bus.update_req_index = 8'h31; bus.update_req_data = 32'h9; bus.update_req_valid = 1'b1;
    @(negedge clk);
    chk("t5_clear_upd_ready", bus.update_req_ready, 0);
    @(posedge clk); #1;
    table_clear = 1'b0;
    bus.update_req_valid = 1'b0;
    chk("t5_clear_count", entry_count, 0);
    lookup_check("t5_post_k30", 8'h30, 4'd12, 1'b0, MISS);
    lookup_check("t5_post_k31", 8'h31, 4'd13, 1'b0, MISS);

    // Asynchronous reset with two lookups in flight
    do_update(8'h60, 32'h66);
    bus.lookup_req_index = 8'h60; bus.lookup_req_user = 4'd14; bus.lookup_req_valid = 1'b1;
    @(posedge clk); #1;
    bus.lookup_req_index = 8'h61; bus.lookup_req_user = 4'd15;
    @(posedge clk); #1;
    bus.lookup_req_valid = 1'b0;
    chk("t6_inflight_valid", bus.lookup_value_valid, 1);
    #1 rst = 1'b0;
    #1;
    chk("t6_async_valid", bus.lookup_value_valid, 0);
    chk("t6_async_lk_ready", bus.lookup_req_ready, 0);
    chk("t6_async_count", entry_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_post_count", entry_count, 0);
    chk("t6_post_valid", bus.lookup_value_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
